// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder state codes and lane helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Responder state codes, kept as plain constants for the legacy encoding.
  typedef logic [2:0] slv_state_t;
  localparam slv_state_t ST_IDLE = 3'd0;
  localparam slv_state_t ST_WAIT = 3'd1;
  localparam slv_state_t ST_ACC  = 3'd2;
  localparam slv_state_t ST_ERR1 = 3'd3;
  localparam slv_state_t ST_ERR2 = 3'd4;

  // Decoder regions, haddr[31:24].
  localparam logic [7:0] REGION_ROM = 8'hA0;
  localparam logic [7:0] REGION_RAM = 8'hB0;

  // Byte-lane enables for a transfer of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << off;
      HSIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replace the enabled byte lanes of old_w with the same lanes of new_w.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// DEPTH x 32 synchronous RAM with byte-enable write port and one registered read port.
// Latency: read data appears one clock after rd_en; writes land on the same edge.
// Backpressure: none; every enabled access is serviced on its edge.
module ahb_sram_mem #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [3:0]               wr_be,
  input  logic [31:0]              wr_dat,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_dat
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  // Registered read, holds its value between enabled reads (read-before-write on collisions).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_dat <= '0;
    else if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM responder: legality check, wait-state FSM, byte-lane writes, read-after-write forwarding.
// Latency: OKAY data phase is WAIT_STATES+1 cycles; ERROR data phase is always 2 cycles.
// Backpressure: hreadyout low in WAIT and ERR1; address phases are only taken while hready is high.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [22:0] DEPTH_W = 23'(DEPTH);

  slv_state_t    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;

  logic          addr_vld, addr_bad, take_ok;
  logic [AW-1:0] addr_idx;
  logic [3:0]    addr_be;

  logic [AW-1:0] cap_idx;
  logic [3:0]    cap_be;
  logic          cap_write;

  logic          wr_en, rd_en;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_q;

  logic          fwd_vld;
  logic [31:0]   fwd_dat;
  logic [3:0]    fwd_be;

  logic          unused_bits;

  assign addr_vld    = hsel & hready & htrans[1];
  assign addr_idx    = haddr[AW+1:2];
  assign addr_be     = lane_mask(hsize, haddr[1:0]);
  // Top byte is the decoder's business; htrans[0] only separates NONSEQ from SEQ.
  assign unused_bits = ^{haddr[31:24], htrans[0]};

  // Flag sizes above a word, misaligned halfwords/words and offsets past the end of the array.
  always_comb begin
    addr_bad = 1'b0;
    if (hsize > HSIZE_WORD)                           addr_bad = 1'b1;
    if ((hsize == HSIZE_HALF) && haddr[0])            addr_bad = 1'b1;
    if ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00)) addr_bad = 1'b1;
    if ({1'b0, haddr[23:2]} >= DEPTH_W)               addr_bad = 1'b1;
  end

  // Next state: IDLE/ACC/ERR2 follow the address phase sampled on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_ok   = 1'b0;
    case (state)
      ST_WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = ST_ACC;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (!addr_vld) begin
          state_nxt = ST_IDLE;
        end else if (addr_bad) begin
          state_nxt = ST_ERR1;
        end else begin
          take_ok = 1'b1;
          if (WS != 4'd0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS;
          end else begin
            state_nxt = ST_ACC;
          end
        end
      end
    endcase
  end

  // State and wait counter; reset aborts any transfer in flight.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Hold the legal transfer's attributes for the rest of its data phase.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      cap_idx   <= '0;
      cap_be    <= 4'd0;
      cap_write <= 1'b0;
    end else if (take_ok) begin
      cap_idx   <= addr_idx;
      cap_be    <= addr_be;
      cap_write <= hwrite;
    end
  end

  // Writes commit on the edge that ends ACC; reads load on the edge that enters ACC.
  assign wr_en = (state == ST_ACC) & cap_write;

  // Read source: live bus when entering ACC directly, captured index when leaving WAIT.
  always_comb begin
    rd_idx = addr_idx;
    rd_en  = take_ok & ~hwrite & (WS == 4'd0);
    if (state == ST_WAIT) begin
      rd_idx = cap_idx;
      rd_en  = (cnt == 4'd1) & ~cap_write;
    end
  end

  ahb_sram_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk   (hclk),
    .rst   (hreset),
    .wr_en (wr_en),
    .wr_idx(cap_idx),
    .wr_be (cap_be),
    .wr_dat(hwdata),
    .rd_en (rd_en),
    .rd_idx(rd_idx),
    .rd_dat(rd_q)
  );

  // A read that samples the array on the same edge a write to that word commits sees
  // the old word; remember the write's lanes so they can be overlaid onto hrdata.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      fwd_vld <= 1'b0;
      fwd_dat <= '0;
      fwd_be  <= 4'd0;
    end else if (rd_en) begin
      fwd_vld <= wr_en & (rd_idx == cap_idx);
      fwd_dat <= hwdata;
      fwd_be  <= cap_be;
    end
  end

  assign hrdata    = merge_lanes(rd_q, fwd_dat, fwd_vld ? fwd_be : 4'b0000);
  assign hreadyout = (state != ST_WAIT) && (state != ST_ERR1);
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Scoreboard bench: two responders (0 and 3 wait states), each looping hreadyout into hready.
// Drivers push expected responses; per-instance monitors pop and compare at data-phase end.
module tb_ahb_ram_slave;
  import ahb_pkg::*;

  localparam int DEPTH = 64;
  localparam logic [31:0] B = {REGION_RAM, 24'h000000};

  typedef struct {
    logic        resp;
    logic        chk;
    logic [31:0] data;
    int          waits;
    int          id;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset   [2];
  logic        hsel_w   [2];
  logic [31:0] haddr_w  [2];
  logic [1:0]  htrans_w [2];
  logic        hwrite_w [2];
  logic [2:0]  hsize_w  [2];
  logic [31:0] hwdata_w [2];
  logic        rdy_w    [2];
  logic        resp_w   [2];
  logic [31:0] rdata_w  [2];
  logic        trk      [2];
  logic [31:0] nxt_wd   [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   tid = 0;

  always #5 hclk = ~hclk;

  ahb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset[0]), .hsel(hsel_w[0]), .haddr(haddr_w[0]),
    .htrans(htrans_w[0]), .hwrite(hwrite_w[0]), .hsize(hsize_w[0]), .hwdata(hwdata_w[0]),
    .hready(rdy_w[0]), .hreadyout(rdy_w[0]), .hresp(resp_w[0]), .hrdata(rdata_w[0])
  );

  ahb_ram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset[1]), .hsel(hsel_w[1]), .haddr(haddr_w[1]),
    .htrans(htrans_w[1]), .hwrite(hwrite_w[1]), .hsize(hsize_w[1]), .hwdata(hwdata_w[1]),
    .hready(rdy_w[1]), .hreadyout(rdy_w[1]), .hresp(resp_w[1]), .hrdata(rdata_w[1])
  );

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", what, act, req);
  endtask

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop_exp(input int d, output exp_t e);
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  // Drive one address phase (and the previous phase's write data), hold until accepted.
  task automatic ap(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                    input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                    input logic tracked, input logic eresp, input logic echk,
                    input logic [31:0] edata, input int ewaits);
    exp_t e;
    int   n;
    hsel_w[d]   = sel;
    htrans_w[d] = tr;
    hwrite_w[d] = wr;
    hsize_w[d]  = sz;
    haddr_w[d]  = addr;
    hwdata_w[d] = nxt_wd[d];
    nxt_wd[d]   = wd;
    trk[d]      = tracked;
    if (tracked) begin
      e.resp = eresp; e.chk = echk; e.data = edata; e.waits = ewaits; e.id = tid;
      tid++;
      push_exp(d, e);
    end
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!rdy_w[d] && n < 50);
    if (!rdy_w[d]) begin
      n_total++;
      $display("FAIL dut%0d hready timeout: hreadyout stuck at 0, required 1", d);
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic wr(input int d, input logic [2:0] sz, input logic [31:0] addr,
                    input logic [31:0] wd, input logic eresp, input int ewaits);
    ap(d, 1'b1, HTRANS_NONSEQ, 1'b1, sz, addr, wd, 1'b1, eresp, 1'b0, 32'h0, ewaits);
  endtask

  task automatic rd(input int d, input logic [2:0] sz, input logic [31:0] addr,
                    input logic eresp, input logic [31:0] edata, input int ewaits);
    ap(d, 1'b1, HTRANS_SEQ, 1'b0, sz, addr, 32'h0, 1'b1, eresp, ~eresp, edata, ewaits);
  endtask

  task automatic idle(input int d);
    ap(d, 1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  // Watch one responder: count wait cycles, compare response and data when hreadyout rises.
  task automatic mon(input int d);
    bit   pend = 0;
    int   w = 0;
    logic r1 = 1'b0;
    exp_t e;
    forever begin
      @(negedge hclk);
      if (hreset[d]) begin
        pend = 0;
        if (d == 0) q0.delete();
        else q1.delete();
      end else begin
        if (pend) begin
          if (!rdy_w[d]) begin
            w++;
            r1 = r1 | resp_w[d];
          end else begin
            pend = 0;
            if (qsize(d) == 0) begin
              n_total++;
              $display("FAIL dut%0d unexpected data phase: no expectation queued", d);
            end else begin
              pop_exp(d, e);
              check($sformatf("dut%0d t%0d hresp", d, e.id), resp_w[d], e.resp);
              check($sformatf("dut%0d t%0d waits", d, e.id), w, e.waits);
              if (w > 0) check($sformatf("dut%0d t%0d hresp in wait", d, e.id), r1, e.resp);
              if (e.chk) check($sformatf("dut%0d t%0d hrdata", d, e.id), rdata_w[d], e.data);
            end
          end
        end
        if (rdy_w[d] && trk[d]) begin
          pend = 1;
          w = 0;
          r1 = 1'b0;
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hreset[d] = 1'b1; hsel_w[d] = 1'b0; haddr_w[d] = 32'h0; htrans_w[d] = 2'd0;
      hwrite_w[d] = 1'b0; hsize_w[d] = 3'd0; hwdata_w[d] = 32'h0; trk[d] = 1'b0;
      nxt_wd[d] = 32'h0;
    end
    repeat (3) @(posedge hclk);
    #1;
    hreset[0] = 1'b0;
    hreset[1] = 1'b0;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset hreadyout", d), rdy_w[d], 32'h1);
      check($sformatf("dut%0d reset hresp", d), resp_w[d], 32'h0);
      check($sformatf("dut%0d reset hrdata", d), rdata_w[d], 32'h0);
    end
    @(posedge hclk);
    #1;

    // Zero-wait instance: write/read, forwarding, errors, boundaries, IDLE/BUSY.
    wr(0, HSIZE_WORD, B + 32'h10, 32'hDEADBEEF, HRESP_OKAY, 0);
    rd(0, HSIZE_WORD, B + 32'h10, HRESP_OKAY, 32'hDEADBEEF, 0);
    wr(0, HSIZE_WORD, B + 32'h10, 32'h11223344, HRESP_OKAY, 0);
    wr(0, HSIZE_BYTE, B + 32'h11, 32'h55555555, HRESP_OKAY, 0);
    rd(0, HSIZE_WORD, B + 32'h10, HRESP_OKAY, 32'h11225544, 0);
    wr(0, HSIZE_HALF, B + 32'h12, 32'hAAAAAAAA, HRESP_OKAY, 0);
    rd(0, HSIZE_WORD, B + 32'h10, HRESP_OKAY, 32'hAAAA5544, 0);
    wr(0, HSIZE_WORD, B + 32'h00, 32'h01020304, HRESP_OKAY, 0);
    wr(0, HSIZE_HALF, B + 32'h01, 32'hFFFFFFFF, HRESP_ERROR, 1);
    rd(0, HSIZE_WORD, B + 32'h00, HRESP_OKAY, 32'h01020304, 0);
    rd(0, HSIZE_WORD, B + 32'h12, HRESP_ERROR, 32'h0, 1);
    rd(0, 3'd3, B + 32'h10, HRESP_ERROR, 32'h0, 1);
    wr(0, HSIZE_WORD, B + 32'(4 * DEPTH - 4), 32'h0F0F0F0F, HRESP_OKAY, 0);
    wr(0, HSIZE_WORD, B + 32'(4 * DEPTH), 32'hFFFFFFFF, HRESP_ERROR, 1);
    rd(0, HSIZE_WORD, B + 32'(4 * DEPTH - 4), HRESP_OKAY, 32'h0F0F0F0F, 0);
    rd(0, HSIZE_WORD, B + 32'h00, HRESP_OKAY, 32'h01020304, 0);
    ap(0, 1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, B + 32'h10, 32'hFFFFFFFF, 1'b1, HRESP_OKAY, 1'b0, 32'h0, 0);
    ap(0, 1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, B + 32'h10, 32'hFFFFFFFF, 1'b1, HRESP_OKAY, 1'b0, 32'h0, 0);
    rd(0, HSIZE_WORD, B + 32'h10, HRESP_OKAY, 32'hAAAA5544, 0);
    rd(0, HSIZE_BYTE, B + 32'h13, HRESP_OKAY, 32'hAAAA5544, 0);
    idle(0);

    // Three-wait-state instance.
    wr(1, HSIZE_WORD, B + 32'h20, 32'hCAFEF00D, HRESP_OKAY, 3);
    rd(1, HSIZE_WORD, B + 32'h20, HRESP_OKAY, 32'hCAFEF00D, 3);
    wr(1, HSIZE_HALF, B + 32'h01, 32'hFFFFFFFF, HRESP_ERROR, 1);
    wr(1, HSIZE_BYTE, B + 32'h23, 32'h77777777, HRESP_OKAY, 3);
    rd(1, HSIZE_WORD, B + 32'h20, HRESP_OKAY, 32'h77FEF00D, 3);
    idle(1);

    // Reset in the middle of a write's wait states: write must be dropped.
    hsel_w[1] = 1'b1; htrans_w[1] = HTRANS_NONSEQ; hwrite_w[1] = 1'b1;
    hsize_w[1] = HSIZE_WORD; haddr_w[1] = B + 32'h20; trk[1] = 1'b0;
    @(posedge hclk);
    #1;
    hsel_w[1] = 1'b0; htrans_w[1] = HTRANS_IDLE; hwrite_w[1] = 1'b0;
    hwdata_w[1] = 32'h12345678;
    @(negedge hclk);
    check("dut1 hreadyout in wait before reset", rdy_w[1], 32'h0);
    hreset[1] = 1'b1;
    #1;
    check("dut1 mid-wait reset hreadyout", rdy_w[1], 32'h1);
    check("dut1 mid-wait reset hresp", resp_w[1], 32'h0);
    check("dut1 mid-wait reset hrdata", rdata_w[1], 32'h0);
    @(negedge hclk);
    hreset[1] = 1'b0;
    nxt_wd[1] = 32'h0;
    @(posedge hclk);
    #1;
    rd(1, HSIZE_WORD, B + 32'h20, HRESP_OKAY, 32'h77FEF00D, 3);
    idle(1);

    repeat (3) @(posedge hclk);
    check("dut0 leftover expectations", q0.size(), 32'h0);
    check("dut1 leftover expectations", q1.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
